// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, FSM encodings
// and the NOP word used as the empty IF/ID payload.
package if_stage_pkg;

  localparam int WordAddrBus = 30;
  localparam int WordDataBus = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2
  } if_state_e;

  localparam logic [WordDataBus-1:0] NOP_INSN = 32'h0000_0000;

  function automatic logic [WordAddrBus-1:0] pc_inc(input logic [WordAddrBus-1:0] pc);
    return pc + 30'd1;
  endfunction

endpackage

// File: rtl/if_stage_if_reg.sv
// IF/ID output register with a one-entry skid buffer that catches a fetch
// completing while the downstream stage is stalled.
module if_reg
  import if_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [WordDataBus-1:0] in_insn,
  input  logic [WordAddrBus-1:0] in_pc,
  output logic [WordAddrBus-1:0] if_pc,
  output logic [WordDataBus-1:0] if_insn,
  output logic                   if_en,
  output logic                   skid_full
);

  logic [WordAddrBus-1:0] if_pc_q, if_pc_d;
  logic [WordDataBus-1:0] if_insn_q, if_insn_d;
  logic                   if_en_q, if_en_d;
  logic                   skid_full_q, skid_full_d;
  logic [WordAddrBus-1:0] skid_pc_q, skid_pc_d;
  logic [WordDataBus-1:0] skid_insn_q, skid_insn_d;

  // Redirect wins over stall; a pending skid entry drains before new bus data.
  always_comb begin
    if_pc_d     = if_pc_q;
    if_insn_d   = if_insn_q;
    if_en_d     = if_en_q;
    skid_full_d = skid_full_q;
    skid_pc_d   = skid_pc_q;
    skid_insn_d = skid_insn_q;
    if (clear) begin
      if_en_d     = 1'b0;
      skid_full_d = 1'b0;
    end else if (stall) begin
      if (in_valid) begin
        skid_full_d = 1'b1;
        skid_pc_d   = in_pc;
        skid_insn_d = in_insn;
      end else begin
        skid_full_d = skid_full_q;
      end
    end else if (skid_full_q) begin
      if_pc_d     = skid_pc_q;
      if_insn_d   = skid_insn_q;
      if_en_d     = 1'b1;
      skid_full_d = 1'b0;
    end else if (in_valid) begin
      if_pc_d   = in_pc;
      if_insn_d = in_insn;
      if_en_d   = 1'b1;
    end else begin
      if_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_pc_q     <= {WordAddrBus{1'b0}};
      if_insn_q   <= NOP_INSN;
      if_en_q     <= 1'b0;
      skid_full_q <= 1'b0;
      skid_pc_q   <= {WordAddrBus{1'b0}};
      skid_insn_q <= NOP_INSN;
    end else begin
      if_pc_q     <= if_pc_d;
      if_insn_q   <= if_insn_d;
      if_en_q     <= if_en_d;
      skid_full_q <= skid_full_d;
      skid_pc_q   <= skid_pc_d;
      skid_insn_q <= skid_insn_d;
    end
  end

  assign if_pc     = if_pc_q;
  assign if_insn   = if_insn_q;
  assign if_en     = if_en_q;
  assign skid_full = skid_full_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, bus request FSM and redirect/discard handling;
// the IF/ID register and skid buffer live in if_reg.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [WordAddrBus-1:0] RESET_VECTOR = 30'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [WordAddrBus-1:0] new_pc,
  input  logic                   br_taken,
  input  logic [WordAddrBus-1:0] br_addr,
  output logic                   bus_req,
  input  logic                   bus_gnt,
  output logic [WordAddrBus-1:0] bus_addr,
  input  logic                   bus_rdy,
  input  logic [WordDataBus-1:0] bus_rd_data,
  output logic [WordAddrBus-1:0] if_pc,
  output logic [WordDataBus-1:0] if_insn,
  output logic                   if_en,
  output logic                   busy
);

  if_state_e              state_q, state_d;
  logic [WordAddrBus-1:0] pc_q, pc_d;
  logic                   discard_q, discard_d;
  logic                   bus_req_q, bus_req_d;
  logic [WordAddrBus-1:0] bus_addr_q, bus_addr_d;
  logic                   busy_s;
  logic                   redirect;
  logic                   fetch_done;
  logic                   accept;
  logic                   skid_full;

  assign redirect   = flush | br_taken;
  assign fetch_done = (state_q == ACCESS) && bus_rdy;
  assign accept     = fetch_done && !discard_q && !redirect;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!stall && !skid_full) state_d = REQ;
        else                      state_d = IDLE;
      end
      REQ: begin
        if (bus_gnt) state_d = ACCESS;
        else         state_d = REQ;
      end
      ACCESS: begin
        if (bus_rdy) state_d = IDLE;
        else         state_d = ACCESS;
      end
      default: state_d = IDLE;
    endcase
  end

  // The fetch address is captured at grant so a redirect cannot disturb a live access.
  always_comb begin
    bus_req_d  = (state_d != IDLE);
    bus_addr_d = {WordAddrBus{1'b0}};
    if (state_d == ACCESS) begin
      if (state_q == ACCESS) bus_addr_d = bus_addr_q;
      else                   bus_addr_d = pc_q;
    end else begin
      bus_addr_d = {WordAddrBus{1'b0}};
    end
    busy_s = (state_q != IDLE) && !stall;
  end

  always_comb begin
    pc_d = pc_q;
    if (flush)         pc_d = new_pc;
    else if (br_taken) pc_d = br_addr;
    else if (accept)   pc_d = pc_inc(pc_q);
    else               pc_d = pc_q;
  end

  // An access granted before a redirect still runs to bus_rdy, but its data is dropped.
  always_comb begin
    discard_d = discard_q;
    if (fetch_done) begin
      discard_d = 1'b0;
    end else if (redirect && ((state_q == ACCESS) || ((state_q == REQ) && bus_gnt))) begin
      discard_d = 1'b1;
    end else begin
      discard_d = discard_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_VECTOR;
      discard_q  <= 1'b0;
      bus_req_q  <= 1'b0;
      bus_addr_q <= {WordAddrBus{1'b0}};
    end else begin
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      bus_req_q  <= bus_req_d;
      bus_addr_q <= bus_addr_d;
    end
  end

  if_reg u_if_reg (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .clear     (redirect),
    .in_valid  (accept),
    .in_insn   (bus_rd_data),
    .in_pc     (pc_inc(bus_addr_q)),
    .if_pc     (if_pc),
    .if_insn   (if_insn),
    .if_en     (if_en),
    .skid_full (skid_full)
  );

  assign bus_req  = bus_req_q;
  assign bus_addr = bus_addr_q;
  assign busy     = busy_s;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: the main thread plays the bus arbiter/memory
// and pushes expected IF/ID outputs; a monitor pops them as ID consumes them.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, br_taken;
  logic [29:0] new_pc, br_addr, bus_addr, if_pc;
  logic        bus_req, bus_gnt, bus_rdy, if_en, busy;
  logic [31:0] bus_rd_data, if_insn;

  typedef struct packed {
    logic [31:0] insn;
    logic [29:0] pc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   rel;

  if_stage #(.RESET_VECTOR(30'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .new_pc     (new_pc),
    .br_taken   (br_taken),
    .br_addr    (br_addr),
    .bus_req    (bus_req),
    .bus_gnt    (bus_gnt),
    .bus_addr   (bus_addr),
    .bus_rdy    (bus_rdy),
    .bus_rd_data(bus_rd_data),
    .if_pc      (if_pc),
    .if_insn    (if_insn),
    .if_en      (if_en),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic chka(input string name, input logic [29:0] act, input logic [29:0] req);
    chk(name, {2'b00, act}, {2'b00, req});
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    chk(name, {31'd0, act}, {31'd0, req});
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] insn, input logic [29:0] pc);
    exp_t e;
    e.insn = insn;
    e.pc   = pc;
    exp_q.push_back(e);
  endtask

  task automatic wait_req();
    int n = 0;
    while (bus_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk1("bus_req_seen", bus_req, 1'b1);
  endtask

  // One complete handshake: grant on the first request cycle, rdy the cycle after.
  task automatic serve(input logic [31:0] data, input logic [29:0] exp_addr);
    wait_req();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    chka("bus_addr", bus_addr, exp_addr);
    bus_rdy     = 1'b1;
    bus_rd_data = data;
    tick();
    bus_rdy     = 1'b0;
    bus_rd_data = 32'h0;
  endtask

  task automatic chk_reset_outputs();
    chk1("rst_bus_req", bus_req, 1'b0);
    chka("rst_bus_addr", bus_addr, 30'h0);
    chka("rst_if_pc", if_pc, 30'h0);
    chk("rst_if_insn", if_insn, 32'h0);
    chk1("rst_if_en", if_en, 1'b0);
    chk1("rst_busy", busy, 1'b0);
  endtask

  // ID consumes an instruction whenever if_en is high and it is not stalling.
  always @(negedge clk) begin
    if (!reset && if_en && !stall) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got insn %h pc %h, nothing expected", if_insn, if_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_insn", if_insn, mon_e.insn);
        chka("sb_pc", if_pc, mon_e.pc);
      end
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
    new_pc = 30'h0; br_addr = 30'h0;
    bus_gnt = 1'b0; bus_rdy = 1'b0; bus_rd_data = 32'h0;
    tick();
    tick();
    chk_reset_outputs();

    // First fetch after reset: if_en on the third cycle after release.
    push_exp(32'hA5A5_0001, 30'd1);
    reset = 1'b0;
    rel   = cyc;
    serve(32'hA5A5_0001, 30'h0);
    chk("first_latency", cyc - rel, 32'd3);
    chk1("first_if_en", if_en, 1'b1);
    chk("first_if_insn", if_insn, 32'hA5A5_0001);
    chka("first_if_pc", if_pc, 30'd1);

    // Stall raised before rdy: data parks in the skid, outputs hold, no new request.
    push_exp(32'h1234_5678, 30'd2);
    wait_req();
    bus_gnt = 1'b1;
    stall   = 1'b1;
    tick();
    bus_gnt = 1'b0;
    chka("stall_bus_addr", bus_addr, 30'd1);
    chk1("stall_busy", busy, 1'b0);
    bus_rdy     = 1'b1;
    bus_rd_data = 32'h1234_5678;
    tick();
    bus_rdy = 1'b0;
    chk1("stall_if_en_hold", if_en, 1'b0);
    chk("stall_if_insn_hold", if_insn, 32'hA5A5_0001);
    chka("stall_if_pc_hold", if_pc, 30'd1);
    chk1("skid_no_req_a", bus_req, 1'b0);
    tick();
    chk1("skid_no_req_b", bus_req, 1'b0);
    chk1("stall_if_en_hold2", if_en, 1'b0);
    stall = 1'b0;
    tick();
    chk1("drain_if_en", if_en, 1'b1);
    chk("drain_if_insn", if_insn, 32'h1234_5678);
    chka("drain_if_pc", if_pc, 30'd2);
    chk1("drain_no_req", bus_req, 1'b0);

    // Branch during ACCESS: old data dropped, refetch from br_addr.
    wait_req();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    chka("br_old_addr", bus_addr, 30'd2);
    chk1("access_busy", busy, 1'b1);
    br_taken = 1'b1;
    br_addr  = 30'h100;
    tick();
    br_taken = 1'b0;
    chk1("br_if_en_low", if_en, 1'b0);
    chka("br_addr_held", bus_addr, 30'd2);
    bus_rdy     = 1'b1;
    bus_rd_data = 32'hDEAD_0002;
    tick();
    bus_rdy = 1'b0;
    chk1("br_drop_if_en", if_en, 1'b0);
    chk1("br_req_drop", bus_req, 1'b0);
    push_exp(32'hC0DE_0100, 30'h101);
    serve(32'hC0DE_0100, 30'h100);

    // flush and br_taken together: flush target wins; rdy in same cycle dropped.
    wait_req();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    chka("fl_old_addr", bus_addr, 30'h101);
    flush = 1'b1; new_pc = 30'h40;
    br_taken = 1'b1; br_addr = 30'h80;
    bus_rdy = 1'b1; bus_rd_data = 32'hBAD0_0101;
    tick();
    flush = 1'b0; br_taken = 1'b0; bus_rdy = 1'b0;
    chk1("fl_if_en_low", if_en, 1'b0);
    push_exp(32'h1111_0040, 30'h41);
    serve(32'h1111_0040, 30'h40);

    // PC wrap at the top of the word address space.
    flush  = 1'b1;
    new_pc = 30'h3FFF_FFFF;
    tick();
    flush = 1'b0;
    push_exp(32'h2222_FFFF, 30'h0);
    serve(32'h2222_FFFF, 30'h3FFF_FFFF);
    chk1("wrap_if_en", if_en, 1'b1);
    chka("wrap_if_pc", if_pc, 30'h0);
    push_exp(32'h3333_0000, 30'd1);
    serve(32'h3333_0000, 30'h0);

    // Reset mid-ACCESS; the late rdy must be ignored.
    wait_req();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_outputs();
    bus_rdy     = 1'b1;
    bus_rd_data = 32'hDEAD_0039;
    tick();
    bus_rdy = 1'b0;
    chk1("late_rdy_if_en", if_en, 1'b0);
    chk("late_rdy_if_insn", if_insn, 32'h0);
    push_exp(32'h4444_0000, 30'd1);
    serve(32'h4444_0000, 30'h0);

    tick();
    tick();
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
